// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, opcodes, and fetch-stage encodings.
package mips_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    localparam logic [5:0] OP_JUMP = 6'b010000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_LD   = 6'b100011;
    localparam logic [5:0] OP_ST   = 6'b101011;
    localparam logic [5:0] OP_LDI  = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // What the fetch stage does this cycle; chosen by pc_next_sel.
    typedef enum logic [2:0] {
        ACT_NONE    = 3'd0,  // idle/halted, nothing happens
        ACT_START   = 3'd1,  // begin a program at start_addr
        ACT_BRANCH  = 3'd2,  // redirect from execute, squash
        ACT_STALL   = 3'd3,  // hold everything
        ACT_HALT    = 3'd4,  // halt opcode seen, no delivery
        ACT_JUMP    = 3'd5,  // jump consumed in fetch, one bubble
        ACT_DELIVER = 3'd6,  // deliver word, pc+1
        ACT_LAST    = 3'd7   // deliver word, then halt
    } fetch_act_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Combinational next-PC priority mux for the fetch stage.
// Priority in RUN: branch > stall > halt opcode > jump opcode > sequential.
module pc_next_sel #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LAST_ADDR = 80,
    parameter logic [5:0]  JUMP_OP   = 6'b010000,
    parameter logic [5:0]  HALT_OP   = 6'b111111
) (
    input  logic              run,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic [2:0]        action
);
    import mips_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

    fetch_act_t act;

    // Pick the per-cycle action and the matching next PC.
    always_comb begin
        next_pc = pc;
        act     = ACT_NONE;
        if (!run) begin
            if (start) begin
                next_pc = start_addr;
                act     = ACT_START;
            end
        end else if (branch_taken) begin
            next_pc = branch_target;
            act     = ACT_BRANCH;
        end else if (stall) begin
            act = ACT_STALL;
        end else if (opcode == HALT_OP) begin
            act = ACT_HALT;
        end else if (opcode == JUMP_OP) begin
            next_pc = jump_target;
            act     = ACT_JUMP;
        end else if (pc >= LAST_PC) begin
            // Targets past the last populated word are legal; the first
            // sequential fetch there still delivers, then stops.
            act = ACT_LAST;
        end else begin
            next_pc = pc + ADDR_W'(1);
            act     = ACT_DELIVER;
        end
    end

    assign action = act;

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: owns the PC, drives instruction memory, latches the
// returned word into the instruction register for decode.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W    = mips_pkg::ADDR_W,
    parameter int unsigned LAST_ADDR = 80,
    parameter logic [5:0]  JUMP_OP   = mips_pkg::OP_JUMP,
    parameter logic [5:0]  HALT_OP   = mips_pkg::OP_HALT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           start_addr,
    input  logic                        stall,
    input  logic                        branch_taken,
    input  logic [ADDR_W-1:0]           branch_target,
    input  logic [mips_pkg::DATA_W-1:0] instr_in,
    output logic [ADDR_W-1:0]           address,
    output logic [mips_pkg::DATA_W-1:0] ir,
    output logic [ADDR_W-1:0]           ir_pc,
    output logic                        ir_valid,
    output logic                        halted,
    output logic [15:0]                 fetch_count
);
    import mips_pkg::*;

    fetch_state_t        state, state_d;
    fetch_act_t          action;
    logic [2:0]          action_raw;
    logic [ADDR_W-1:0]   pc, pc_d, next_pc;
    logic [DATA_W-1:0]   ir_d;
    logic [ADDR_W-1:0]   ir_pc_d;
    logic                ir_valid_d;
    logic [15:0]         fetch_count_d;
    logic                run;

    assign run     = (state == ST_RUN);
    assign address = pc;
    assign halted  = (state == ST_HALT);

    pc_next_sel #(
        .ADDR_W   (ADDR_W),
        .LAST_ADDR(LAST_ADDR),
        .JUMP_OP  (JUMP_OP),
        .HALT_OP  (HALT_OP)
    ) u_pc_next_sel (
        .run          (run),
        .start        (start),
        .start_addr   (start_addr),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .opcode       (instr_in[31:26]),
        .jump_target  (instr_in[ADDR_W-1:0]),
        .pc           (pc),
        .next_pc      (next_pc),
        .action       (action_raw)
    );

    assign action = fetch_act_t'(action_raw);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next datapath values from the selected action.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        ir_d          = ir;
        ir_pc_d       = ir_pc;
        ir_valid_d    = ir_valid;
        fetch_count_d = fetch_count;
        unique case (action)
            ACT_START: begin
                state_d       = ST_RUN;
                pc_d          = next_pc;
                ir_valid_d    = 1'b0;
                fetch_count_d = '0;
            end
            ACT_BRANCH, ACT_JUMP: begin
                pc_d       = next_pc;
                ir_valid_d = 1'b0;
            end
            ACT_STALL: begin
            end
            ACT_HALT: begin
                state_d    = ST_HALT;
                ir_valid_d = 1'b0;
            end
            ACT_DELIVER, ACT_LAST: begin
                pc_d       = next_pc;
                ir_d       = instr_in;
                ir_pc_d    = pc;
                ir_valid_d = 1'b1;
                if (fetch_count != 16'hFFFF) begin
                    fetch_count_d = fetch_count + 16'd1;
                end
                if (action == ACT_LAST) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                // IDLE/HALT with no start: nothing live in ir.
                ir_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= '0;
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc          <= pc_d;
            ir          <= ir_d;
            ir_pc       <= ir_pc_d;
            ir_valid    <= ir_valid_d;
            fetch_count <= fetch_count_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Program-counter and fetch stage for the MIPS datapath; sits directly upstream of the instruction memory.
- Drives the 10-bit word address and latches the returned 32-bit word into an instruction register for the decode stage.
- Resolves unconditional jumps locally.
- Accepts branch redirects from execute.
- Supports stall, program selection by start address, and halt.

Parameters:
ADDR_W, 10, word-address width (matches instruction memory)
LAST_ADDR, 80, highest populated memory word; fetching past it halts
JUMP_OP, 6'b010000, opcode resolved inside fetch (target = instr[ADDR_W-1:0])
HALT_OP, 6'b111111, opcode that stops fetch

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse: begin fetching at start_addr (only honoured in IDLE/HALT)
start_addr  in  10  first PC of the selected program (e.g. 0 or 11)
stall  in  1  hold PC and IR (decode not ready)
branch_taken  in  1  redirect from execute (beq/bne resolved)
branch_target  in  10  redirect PC
instr_in  in  32  word from instruction memory (combinational read of address)
address  out  10  current PC to instruction memory
ir  out  32  latched instruction to decode
ir_pc  out  10  PC of the word held in ir
ir_valid  out  1  ir holds a live instruction
halted  out  1  high in HALT state
fetch_count  out  16  instructions delivered with ir_valid since last start (saturating)

Behaviour:
- Reset, applied at any time including mid-program:
  - State IDLE, pc=0, ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0.
  - address = pc (combinational).
- States: IDLE, RUN, HALT.
- IDLE:
  - ir_valid=0.
  - On start: pc<=start_addr, fetch_count<=0, go RUN.
- RUN, priority per cycle (highest first):
  1. branch_taken: pc<=branch_target, ir_valid<=0 (squash word in flight), ignores stall.
  2. stall: pc, ir, ir_pc, ir_valid held unchanged.
  3. instr_in[31:26]==HALT_OP: ir_valid<=0, go HALT, pc held.
  4. instr_in[31:26]==JUMP_OP: pc<=instr_in[9:0], ir_valid<=0 (jump consumed; one bubble).
  5. Otherwise:
     - ir<=instr_in, ir_pc<=pc, ir_valid<=1, fetch_count+1 saturating at 16'hFFFF.
     - If pc==LAST_ADDR: go HALT after delivering this word; else pc<=pc+1.
- Latency: word at address A appears on ir one clock after pc==A (memory read is combinational).
- PC arithmetic is ADDR_W bits. Jump/branch targets above LAST_ADDR are accepted; the next sequential fetch at or past LAST_ADDR halts.
- HALT:
  - halted=1, ir_valid=0, pc frozen, branch_taken ignored.
  - start restarts exactly as from IDLE.
- start asserted in RUN is ignored.
- reset takes precedence over start in the same cycle.
- stall in IDLE/HALT has no effect.
- ir_valid falls the cycle after the flushing event. ir keeps its last value when ir_valid=0 (don't-care for decode).

Decomposition:
- Shared package mips_pkg:
  - ADDR_W, DATA_W=32.
  - Opcode constants OP_JUMP, OP_BEQ, OP_BNE, OP_HALT, OP_LD, OP_ST, OP_LDI.
  - Fetch state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2).
- Single natural sub-module: pc_next_sel, the combinational next-PC priority mux (branch / stall / halt / jump / increment). Remainder stays in one module.

Test Plan:
1. reset, start with start_addr=0, memory holds sequential non-jump words 0..4 -> address 0,1,2,3,4 on consecutive clocks; ir_pc 0..4 one cycle later with ir_valid=1; fetch_count=5.
2. Word at 10 = jump to 5 -> cycle after pc==10, pc==5; ir_valid=0 for exactly one cycle; next ir_pc=5.
3. At pc=7, assert branch_taken with branch_target=21, together with stall=1 -> pc==21 next cycle and ir_valid=0; following cycle ir_pc=21.
4. stall held 3 cycles at pc=3 -> address stays 3; ir/ir_pc/ir_valid unchanged; fetch_count unchanged; resumes at 4 after release.
5. Sequential run reaching pc=LAST_ADDR=80 -> word 80 delivered, then halted=1 and ir_valid=0. A HALT_OP word at 12 also halts with no delivery. start with start_addr=11 restarts at 11 with fetch_count=0.
6. reset asserted mid-RUN at pc=6 -> next cycle IDLE with pc=0, ir_valid=0, halted=0, fetch_count=0. start in the same cycle as reset is ignored.
